data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Memory-side responder for the pipeline MEM-stage data access port.
//  Serves byte/word read and write requests against a byte-addressed, big-endian 8-bit-wide array.
//  Uses a req/ready handshake with a programmable number of wait states.
//  Sits between EX_MEM outputs (address, store data, size, read/write) and the MEM_WB load-data path.
//  Replaces the combinational data RAM when multi-cycle memory timing is exercised.
// PARAMETERS
//  DEPTH        256  number of bytes in the array; addresses >= DEPTH are out of range
//  WAIT_STATES  2    cycles spent in WAIT before the access completes (0..15)
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  Reset      in   1   synchronous, active-high reset
//  req        in   1   request strobe, sampled only in IDLE
//  rw         in   1   1 = write (store), 0 = read (load)
//  size       in   1   1 = word (32 bit), 0 = byte
//  addr       in   32  byte address
//  wdata      in   32  store data; byte store uses wdata[7:0]
//  rdata      out  32  load data, valid while ready=1
//  ready      out  1   one-cycle completion pulse
//  err        out  1   valid with ready; misaligned word access or out-of-range address
//  busy       out  1   high in any state other than IDLE
//  dbg_addr   in   32  (DUMP_PORT_EN only) debug read address, word-aligned
//  dbg_data   out  32  (DUMP_PORT_EN only) registered big-endian word at dbg_addr
// BEHAVIOUR
//  - Reset: state=IDLE, ready=0, err=0, busy=0, rdata=0, wait counter=0, dbg_data=0.
//    Array contents are NOT cleared; the bench preloads them.
//  - FSM: IDLE -> WAIT -> ACCESS -> IDLE.
//    - IDLE, req=1: latch rw/size/addr/wdata and load cnt=WAIT_STATES.
//      Next state is WAIT, or ACCESS if WAIT_STATES==0.
//    - WAIT: cnt decrements each cycle; when cnt==1, next state is ACCESS.
//    - ACCESS: perform the access, drive ready=1 for exactly this cycle, then return to IDLE.
//  - Latency: req sampled at edge N; ready is high in the cycle after edge N+1+WAIT_STATES.
//  - Inputs are ignored outside IDLE. A req held high through ACCESS is re-accepted in the following IDLE cycle.
//    Maximum throughput is one access per WAIT_STATES+2 cycles.
//  - Word access is big-endian: Mem[a]=d[31:24], Mem[a+1]=d[23:16], Mem[a+2]=d[15:8], Mem[a+3]=d[7:0].
//  - Byte read: rdata = {24'b0, Mem[a]}. Byte write modifies Mem[a] only.
//  - Error cases: word with addr[1:0]!=0, or addr > DEPTH-1 (byte) / addr > DEPTH-4 (word).
//    On error: err=1, rdata=0, no array write, ready still pulses with normal latency.
//  - rdata and err are 0 whenever ready=0. Out-of-range is decided on the full 32-bit address (no wrap-around).
//  - Reset asserted in WAIT or ACCESS aborts the request: no write occurs and ready stays 0.
//  - Array writes happen only on the ACCESS clock edge.
// CONFIGURATION
//  - DUMP_PORT_EN defined: adds dbg_addr/dbg_data.
//    dbg_data <= big-endian word at {dbg_addr[31:2],2'b00} each cycle (1-cycle latency).
//    Out-of-range dbg_addr returns 0. Independent of the FSM, so a same-cycle write is seen next cycle.
//  - DUMP_PORT_EN undefined: the dbg ports are absent and there is no extra read logic.
// TESTING
//  1. Preload Mem[0..3]=E0,82,50,05. Word read addr=0, WAIT_STATES=2 -> ready at 4th cycle after req edge,
//     rdata=32'hE0825005, err=0.
//  2. Word write addr=8, wdata=32'h11223344, then byte read addr=10 -> rdata=32'h00000033.
//  3. Word read addr=6 -> ready=1, err=1, rdata=0. Word write addr=252 is accepted; word read addr=253 -> err=1.
//  4. Reset pulsed during WAIT of a word write to addr=16 -> ready never pulses,
//     Mem[16..19] unchanged, busy=0 next cycle.
//  5. req held high for 3 back-to-back byte reads -> ready pulses spaced exactly WAIT_STATES+2 cycles apart.
//     Repeat with WAIT_STATES=0: spacing 2.
//  6. (DUMP_PORT_EN) dbg_addr=8 after test 2 -> dbg_data=32'h11223344 one cycle later.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
// master: drives req/rw/size/addr/wdata; slave: drives rdata/ready/err/busy.
interface data_mem_responder_if;
  logic        req;
  logic        rw;
  logic        size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output req, rw, size, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, rw, size, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle big-endian byte/word data memory responder (IDLE->WAIT->ACCESS).
// Ports: clk, Reset (sync, active-high), bus (slave modport of
// data_mem_responder_if). Optional DUMP_PORT_EN adds dbg_addr/dbg_data.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                Reset,
  data_mem_responder_if.slave bus
`ifdef DUMP_PORT_EN
  ,
  input  logic [31:0]         dbg_addr,
  output logic [31:0]         dbg_data
`endif
);
  localparam int          AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] LAST_B = 32'(DEPTH - 1);
  localparam logic [31:0] LAST_W = 32'(DEPTH - 4);
  localparam logic [3:0]  WS     = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_e;

  state_e      st_q, st_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic        size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [7:0]  mem_q [DEPTH];

  logic          bad;
  logic          do_wr;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [31:0]   rd_word;

  // Range check uses the full address, so high addresses never alias.
  assign bad = size_q
             ? ((addr_q[1:0] != 2'b00) || (addr_q > LAST_W))
             : (addr_q > LAST_B);

  assign i0 = addr_q[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);

  assign rd_word = size_q
                 ? {mem_q[i0], mem_q[i1], mem_q[i2], mem_q[i3]}
                 : {24'h0, mem_q[i0]};

  assign do_wr = (st_q == S_ACCESS) && rw_q && !bad;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = 32'h0;
    unique case (st_q)
      S_IDLE: begin
        if (bus.req) begin
          rw_d    = bus.rw;
          size_d  = bus.size;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          cnt_d   = WS;
          st_d    = (WS == 4'd0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) st_d = S_ACCESS;
      end
      S_ACCESS: begin
        // Response is registered here and shows up in the next IDLE cycle.
        st_d    = S_IDLE;
        ready_d = 1'b1;
        err_d   = bad;
        if (!bad && !rw_q) rdata_d = rd_word;
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      st_q    <= S_IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= 1'b0;
      size_q  <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is not reset; a reset edge suppresses a pending write.
  always_ff @(posedge clk) begin
    if (!Reset && do_wr) begin
      if (size_q) begin
        mem_q[i0] <= wdata_q[31:24];
        mem_q[i1] <= wdata_q[23:16];
        mem_q[i2] <= wdata_q[15:8];
        mem_q[i3] <= wdata_q[7:0];
      end else begin
        mem_q[i0] <= wdata_q[7:0];
      end
    end
  end

  assign bus.ready = ready_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (st_q != S_IDLE);

`ifdef DUMP_PORT_EN
  logic [31:0]   dbg_wa;
  logic [AW-1:0] d0, d1, d2, d3;
  logic          dbg_unused;
  logic [31:0]   dbg_q;

  assign dbg_wa     = {dbg_addr[31:2], 2'b00};
  assign dbg_unused = ^dbg_addr[1:0];
  assign d0 = dbg_wa[AW-1:0];
  assign d1 = d0 + AW'(1);
  assign d2 = d0 + AW'(2);
  assign d3 = d0 + AW'(3);

  always_ff @(posedge clk) begin
    if (Reset) begin
      dbg_q <= 32'h0;
    end else if (dbg_wa > LAST_W) begin
      dbg_q <= 32'h0;
    end else begin
      dbg_q <= {mem_q[d0], mem_q[d1], mem_q[d2], mem_q[d3]};
    end
  end

  assign dbg_data = dbg_q;
`endif
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed cases plus random traffic
// against a byte-array model, on WAIT_STATES=2 and WAIT_STATES=0 copies.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst2, rst0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  data_mem_responder_if b2();
  data_mem_responder_if b0();

`ifdef DUMP_PORT_EN
  logic [31:0] dbg_a2, dbg_d2, dbg_a0, dbg_d0;
`endif

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
    .clk      (clk),
    .Reset    (rst2),
    .bus      (b2)
`ifdef DUMP_PORT_EN
    ,
    .dbg_addr (dbg_a2),
    .dbg_data (dbg_d2)
`endif
  );

  data_mem_responder #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
    .clk      (clk),
    .Reset    (rst0),
    .bus      (b0)
`ifdef DUMP_PORT_EN
    ,
    .dbg_addr (dbg_a0),
    .dbg_data (dbg_d0)
`endif
  );

  logic [7:0] m2 [256];
  logic [7:0] m0 [256];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic rq, rw, sz,
                       input logic [31:0] a, wd);
    if (sel == 0) begin
      b0.req = rq; b0.rw = rw; b0.size = sz;
      b0.addr = a; b0.wdata = wd;
    end else begin
      b2.req = rq; b2.rw = rw; b2.size = sz;
      b2.addr = a; b2.wdata = wd;
    end
  endtask

  function automatic logic rdy(input int sel);
    return (sel == 0) ? b0.ready : b2.ready;
  endfunction

  function automatic logic erro(input int sel);
    return (sel == 0) ? b0.err : b2.err;
  endfunction

  function automatic logic [31:0] rdat(input int sel);
    return (sel == 0) ? b0.rdata : b2.rdata;
  endfunction

  function automatic logic bsy(input int sel);
    return (sel == 0) ? b0.busy : b2.busy;
  endfunction

  function automatic logic experr(input logic sz, input logic [31:0] a);
    longint la;
    la = longint'(a);
    if (sz) return (la % 4 != 0) || (la > 256 - 4);
    return la > 255;
  endfunction

  function automatic logic [7:0] mbyte(input int sel, input longint a);
    int idx;
    idx = int'(a % 256);
    return (sel == 0) ? m0[idx] : m2[idx];
  endfunction

  function automatic logic [31:0] mread(input int sel, input logic sz,
                                        input logic [31:0] a);
    longint la;
    la = longint'(a);
    if (!sz) return {24'h0, mbyte(sel, la)};
    return {mbyte(sel, la), mbyte(sel, la + 1),
            mbyte(sel, la + 2), mbyte(sel, la + 3)};
  endfunction

  task automatic mwrite(input int sel, input logic sz,
                        input logic [31:0] a, wd);
    int n;
    n = sz ? 4 : 1;
    for (int j = 0; j < n; j++) begin
      logic [7:0] b;
      b = sz ? wd[31 - 8*j -: 8] : wd[7:0];
      if (sel == 0) m0[(int'(a) + j) % 256] = b;
      else          m2[(int'(a) + j) % 256] = b;
    end
  endtask

  task automatic xact(input int sel, input logic rw, sz,
                      input logic [31:0] a, wd,
                      output logic [31:0] rd, output logic er,
                      output int lat);
    drive(sel, 1'b1, rw, sz, a, wd);
    step();
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = -1;
    rd  = 32'h0;
    er  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rdy(sel)) begin
        lat = k;
        rd  = rdat(sel);
        er  = erro(sel);
        break;
      end
      chk("quiet", {rdat(sel), erro(sel)}, 33'h0);
      step();
    end
  endtask

  task automatic run(input int sel, input logic rw, sz,
                     input logic [31:0] a, wd, input int ws,
                     input string tag);
    logic        e_er, er;
    logic [31:0] e_rd, rd;
    int          lat;
    e_er = experr(sz, a);
    e_rd = (e_er || rw) ? 32'h0 : mread(sel, sz, a);
    xact(sel, rw, sz, a, wd, rd, er, lat);
    chk({tag, ".lat"}, lat, ws + 1);
    chk({tag, ".err"}, er, e_er);
    if (!rw) chk({tag, ".rdata"}, rd, e_rd);
    if (rw && !e_er) mwrite(sel, sz, a, wd);
  endtask

  task automatic spacing(input int sel, input logic [31:0] a,
                         input int ws, input string tag);
    int          t;
    int          n;
    int          tp [3];
    logic [31:0] e_rd;
    e_rd = mread(sel, 1'b0, a);
    t = 0;
    n = 0;
    tp[0] = 0; tp[1] = 0; tp[2] = 0;
    drive(sel, 1'b1, 1'b0, 1'b0, a, 32'h0);
    for (int k = 0; k < 80 && n < 3; k++) begin
      step();
      t++;
      if (rdy(sel)) begin
        tp[n] = t;
        chk({tag, ".rdata"}, rdat(sel), e_rd);
        n++;
        if (n == 3) drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drive(sel, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk({tag, ".count"}, n, 3);
    chk({tag, ".first"}, tp[0], ws + 2);
    chk({tag, ".gap1"}, tp[1] - tp[0], ws + 2);
    chk({tag, ".gap2"}, tp[2] - tp[1], ws + 2);
    step();
    chk({tag, ".idle"}, bsy(sel), 1'b0);
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic        er, rw, sz;
    int          lat;

    rst2 = 1'b1;
    rst0 = 1'b1;
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`ifdef DUMP_PORT_EN
    dbg_a2 = 32'h0;
    dbg_a0 = 32'h0;
`endif
    step();
    step();
    chk("rst.ready", b2.ready, 1'b0);
    chk("rst.err", b2.err, 1'b0);
    chk("rst.busy", b2.busy, 1'b0);
    chk("rst.rdata", b2.rdata, 32'h0);
    chk("rst0.busy", b0.busy, 1'b0);
`ifdef DUMP_PORT_EN
    chk("rst.dbg", dbg_d2, 32'h0);
`endif
    rst2 = 1'b0;
    rst0 = 1'b0;
    step();

    for (int i = 0; i < 64; i++)
      run(2, 1'b1, 1'b1, 32'(4 * i), $urandom, 2, "fill");

    run(2, 1'b1, 1'b0, 32'd0, 32'hE0, 2, "pre0");
    run(2, 1'b1, 1'b0, 32'd1, 32'h82, 2, "pre1");
    run(2, 1'b1, 1'b0, 32'd2, 32'h50, 2, "pre2");
    run(2, 1'b1, 1'b0, 32'd3, 32'h05, 2, "pre3");
    xact(2, 1'b0, 1'b1, 32'd0, 32'h0, rd, er, lat);
    chk("t1.lat", lat, 3);
    chk("t1.rdata", rd, 32'hE0825005);
    chk("t1.err", er, 1'b0);

    run(2, 1'b1, 1'b1, 32'd8, 32'h11223344, 2, "t2.wr");
    xact(2, 1'b0, 1'b0, 32'd10, 32'h0, rd, er, lat);
    chk("t2.rdata", rd, 32'h00000033);

`ifdef DUMP_PORT_EN
    dbg_a2 = 32'd8;
    step();
    chk("t6.dbg8", dbg_d2, 32'h11223344);
    dbg_a2 = 32'd11;
    step();
    chk("t6.dbg11", dbg_d2, 32'h11223344);
    dbg_a2 = 32'd256;
    step();
    chk("t6.dbgoor", dbg_d2, 32'h0);
`endif

    xact(2, 1'b0, 1'b1, 32'd6, 32'h0, rd, er, lat);
    chk("t3.mis.err", er, 1'b1);
    chk("t3.mis.rdata", rd, 32'h0);
    chk("t3.mis.lat", lat, 3);
    run(2, 1'b1, 1'b1, 32'd252, 32'hA5B6C7D8, 2, "t3.wr252");
    xact(2, 1'b0, 1'b1, 32'd252, 32'h0, rd, er, lat);
    chk("t3.rd252", rd, 32'hA5B6C7D8);
    chk("t3.rd252.err", er, 1'b0);
    run(2, 1'b0, 1'b1, 32'd253, 32'h0, 2, "t3.rd253");
    run(2, 1'b0, 1'b0, 32'd255, 32'h0, 2, "t3.b255");
    run(2, 1'b0, 1'b0, 32'd256, 32'h0, 2, "t3.b256");
    run(2, 1'b1, 1'b1, 32'd256, 32'h0, 2, "t3.w256");
    run(2, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 2, "t3.wrap");
    run(2, 1'b1, 1'b0, 32'h1_0000, 32'h77, 2, "t3.hi");

    drive(2, 1'b1, 1'b1, 1'b1, 32'd16, 32'hDEADBEEF);
    step();
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    chk("t4.busy", b2.busy, 1'b1);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    chk("t4.busy0", b2.busy, 1'b0);
    for (int k = 0; k < 6; k++) begin
      chk("t4.noready", b2.ready, 1'b0);
      step();
    end
    run(2, 1'b0, 1'b1, 32'd16, 32'h0, 2, "t4.rd16");

    spacing(2, 32'd10, 2, "t5.ws2");

    run(0, 1'b1, 1'b0, 32'd5, 32'hAB, 0, "w0.wr5");
    run(0, 1'b1, 1'b1, 32'd12, 32'hCAFEF00D, 0, "w0.wr12");
    run(0, 1'b0, 1'b1, 32'd12, 32'h0, 0, "w0.rd12");
    run(0, 1'b0, 1'b0, 32'd14, 32'h0, 0, "w0.rd14");
    run(0, 1'b0, 1'b1, 32'd13, 32'h0, 0, "w0.mis");
    spacing(0, 32'd5, 0, "t5.ws0");

    for (int i = 0; i < 80; i++) begin
      rw = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'($urandom_range(250, 260));
        default: a = 32'($urandom_range(0, 255));
      endcase
      if (sz && $urandom_range(0, 3) != 0) a = a & ~32'h3;
      run(2, rw, sz, a, wd, 2, "rnd");
    end

`ifdef DUMP_PORT_EN
    a = 32'($urandom_range(0, 63)) * 4;
    dbg_a2 = a;
    step();
    chk("rnd.dbg", dbg_d2, mread(2, 1'b1, a));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
